// File: rtl/inst_fetch_buffer_pkg.sv
// rtl/inst_fetch_buffer_pkg.sv - shared widths and the buffered fetch entry record
package inst_fetch_buffer_pkg;

    localparam int unsigned IFB_ADDR_WIDTH = 32;
    localparam int unsigned IFB_INST_WIDTH = 32;

    typedef struct packed {
        logic [IFB_ADDR_WIDTH-1:0] pc;
        logic [IFB_INST_WIDTH-1:0] inst;
        logic                      branch;
        logic [IFB_ADDR_WIDTH-1:0] branch_addr;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_sync_fifo.sv
// rtl/inst_fetch_buffer_sync_fifo.sv - power-of-two synchronous FIFO of fetch entries with flush
module inst_fetch_buffer_sync_fifo
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i;
    assign do_pop  = pop_i && (count_q != '0);

    // Flush leaves storage untouched; only reset clears the entries themselves.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - fetch-to-decode buffer: one-cycle SRAM read stage feeding a small FIFO
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IFB_ADDR_WIDTH,
    parameter int unsigned INST_WIDTH = IFB_INST_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_branch,
    input  logic [ADDR_WIDTH-1:0] if_branch_addr,
    output logic                  if_ready,
    input  logic                  flush,
    output logic                  inst_sram_en,
    output logic [ADDR_WIDTH-1:0] inst_sram_addr,
    input  logic [INST_WIDTH-1:0] inst_sram_rdata,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_branch,
    output logic [ADDR_WIDTH-1:0] id_branch_addr
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  branch_q;
    logic [ADDR_WIDTH-1:0] branch_addr_q;

    logic [CNT_W-1:0]      count;
    logic [OCC_W-1:0]      occupancy;
    logic                  accept;
    logic                  pop;
    fetch_entry_t          push_data;
    fetch_entry_t          head;

    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready;

    // The in-flight read reserves a slot, so a full FIFO plus a read never overflows.
    assign occupancy = {1'b0, count} + OCC_W'(inflight_q) - OCC_W'(pop);
    assign if_ready  = !rst && !flush && (occupancy < OCC_W'(DEPTH));
    assign accept    = if_valid && if_ready;

    assign inst_sram_en   = accept;
    assign inst_sram_addr = if_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q    <= 1'b0;
            pc_q          <= '0;
            branch_q      <= 1'b0;
            branch_addr_q <= '0;
        end else if (flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                pc_q          <= if_pc;
                branch_q      <= if_branch;
                branch_addr_q <= if_branch_addr;
            end
        end
    end

    assign push_data = '{pc: pc_q, inst: inst_sram_rdata, branch: branch_q,
                         branch_addr: branch_addr_q};

    inst_fetch_buffer_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (inflight_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign id_pc          = head.pc;
    assign id_inst        = head.inst;
    assign id_branch      = head.branch;
    assign id_branch_addr = head.branch_addr;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - directed vector table, corner sequences and random scoreboard run
module tb_inst_fetch_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] P = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_branch = 1'b0;
    logic [31:0] if_branch_addr = '0;
    logic        if_ready;
    logic        flush = 1'b0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_branch;
    logic [31:0] id_branch_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_branch      (if_branch),
        .if_branch_addr (if_branch_addr),
        .if_ready       (if_ready),
        .flush          (flush),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_branch      (id_branch),
        .id_branch_addr (id_branch_addr)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic v, input logic [31:0] pc,
                         input logic br, input logic [31:0] ba, input logic rdy);
        @(negedge clk);
        rst = r; flush = fl; if_valid = v; if_pc = pc;
        if_branch = br; if_branch_addr = ba; id_ready = rdy;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic br, input logic [31:0] ba);
        check({tag, " id_valid"}, 32'(id_valid), 32'd1);
        check({tag, " id_pc"}, id_pc, pc);
        check({tag, " id_inst"}, id_inst, inst);
        check({tag, " id_branch"}, 32'(id_branch), 32'(br));
        check({tag, " id_branch_addr"}, id_branch_addr, ba);
    endtask

    typedef struct {
        logic        r, v, br, rdy;
        logic [31:0] pc, ba;
        logic        e_ready, e_valid, chk, e_br;
        logic [31:0] e_pc, e_inst, e_ba;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                                input logic br, input logic [31:0] ba, input logic rdy,
                                input logic er, input logic ev, input logic chk,
                                input logic [31:0] epc, input logic [31:0] einst,
                                input logic ebr, input logic [31:0] eba);
        vec_t t;
        t.r = r; t.v = v; t.pc = pc; t.br = br; t.ba = ba; t.rdy = rdy;
        t.e_ready = er; t.e_valid = ev; t.chk = chk;
        t.e_pc = epc; t.e_inst = einst; t.e_br = ebr; t.e_ba = eba;
        return t;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic [31:0] ba;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[10];

    initial begin
        vt[0] = mk(1, 0, 0,         0, 0,         0, 0, 0, 1, 0,         0,              0, 0);
        vt[1] = mk(0, 1, P,         0, 0,         1, 1, 0, 1, 0,         0,              0, 0);
        vt[2] = mk(0, 1, P + 4,     0, 0,         1, 1, 0, 1, 0,         0,              0, 0);
        vt[3] = mk(0, 1, P + 8,     0, 0,         1, 1, 1, 1, P,         inst_of(P),     0, 0);
        vt[4] = mk(0, 1, P + 12,    0, 0,         1, 1, 1, 1, P + 4,     inst_of(P + 4), 0, 0);
        vt[5] = mk(0, 1, 32'h40,    1, 32'h3000,  1, 1, 1, 1, P + 8,     inst_of(P + 8), 0, 0);
        vt[6] = mk(0, 1, 32'h44,    0, 0,         1, 1, 1, 1, P + 12,    inst_of(P + 12), 0, 0);
        vt[7] = mk(0, 0, 32'h48,    0, 0,         1, 1, 1, 1, 32'h40,    inst_of(32'h40), 1, 32'h3000);
        vt[8] = mk(0, 0, 32'h48,    0, 0,         1, 1, 1, 1, 32'h44,    inst_of(32'h44), 0, 0);
        vt[9] = mk(0, 0, 32'h48,    0, 0,         1, 1, 0, 0, 0,         0,              0, 0);

        drive(1, 0, 0, 0, 0, 0, 0);

        // streaming, latency and branch tagging
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].r, 1'b0, vt[i].v, vt[i].pc, vt[i].br, vt[i].ba, vt[i].rdy);
            check($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(vt[i].e_ready));
            check($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            check($sformatf("v%0d sram_en", i), 32'(inst_sram_en), 32'(vt[i].v && vt[i].e_ready));
            check($sformatf("v%0d sram_addr", i), inst_sram_addr, vt[i].pc);
            if (vt[i].chk) begin
                check($sformatf("v%0d id_pc", i), id_pc, vt[i].e_pc);
                check($sformatf("v%0d id_inst", i), id_inst, vt[i].e_inst);
                check($sformatf("v%0d id_branch", i), 32'(id_branch), 32'(vt[i].e_br));
                check($sformatf("v%0d id_branch_addr", i), id_branch_addr, vt[i].e_ba);
            end
        end

        // fill to DEPTH with decode stalled, then drain
        drive(0, 0, 1, 32'h500, 0, 0, 0);
        check("full a if_ready", 32'(if_ready), 1);
        drive(0, 0, 1, 32'h504, 0, 0, 0);
        check("full b if_ready", 32'(if_ready), 1);
        drive(0, 0, 1, 32'h508, 0, 0, 0);
        check("full c if_ready", 32'(if_ready), 0);
        check("full c sram_en", 32'(inst_sram_en), 0);
        check_head("full c", 32'h500, inst_of(32'h500), 0, 0);
        drive(0, 0, 1, 32'h508, 0, 0, 0);
        check("full d if_ready", 32'(if_ready), 0);
        drive(0, 0, 1, 32'h508, 0, 0, 1);
        check("full e if_ready", 32'(if_ready), 1);
        check_head("full e", 32'h500, inst_of(32'h500), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("full f if_ready", 32'(if_ready), 1);
        check_head("full f", 32'h504, inst_of(32'h504), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check_head("full g", 32'h508, inst_of(32'h508), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("full h id_valid", 32'(id_valid), 0);

        // flush with one entry queued and one read in flight
        drive(0, 0, 1, 32'h0f0, 0, 0, 0);
        check("flush a if_ready", 32'(if_ready), 1);
        drive(0, 0, 1, 32'h100, 0, 0, 0);
        check("flush b if_ready", 32'(if_ready), 1);
        drive(0, 1, 1, 32'h104, 0, 0, 1);
        check("flush c if_ready", 32'(if_ready), 0);
        check("flush c sram_en", 32'(inst_sram_en), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("flush d id_valid", 32'(id_valid), 0);
        check("flush d if_ready", 32'(if_ready), 1);
        drive(0, 0, 1, 32'h200, 0, 0, 1);
        check("flush e id_valid", 32'(id_valid), 0);
        check("flush e if_ready", 32'(if_ready), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("flush f id_valid", 32'(id_valid), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check_head("flush g", 32'h200, inst_of(32'h200), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("flush h id_valid", 32'(id_valid), 0);

        // reset while full with a read in flight
        drive(0, 0, 1, 32'h600, 1, 32'h7000, 0);
        drive(0, 0, 1, 32'h604, 0, 0, 0);
        drive(0, 0, 1, 32'h608, 0, 0, 0);
        check("rst c if_ready", 32'(if_ready), 0);
        check_head("rst c", 32'h600, inst_of(32'h600), 1, 32'h7000);
        drive(1, 0, 1, 32'h608, 0, 0, 0);
        check("rst d if_ready", 32'(if_ready), 0);
        check("rst d sram_en", 32'(inst_sram_en), 0);
        drive(1, 0, 1, 32'h608, 0, 0, 1);
        check("rst e id_valid", 32'(id_valid), 0);
        check("rst e if_ready", 32'(if_ready), 0);
        check("rst e sram_en", 32'(inst_sram_en), 0);
        check("rst e id_pc", id_pc, 0);
        check("rst e id_inst", id_inst, 0);
        check("rst e id_branch", 32'(id_branch), 0);
        check("rst e id_branch_addr", id_branch_addr, 0);
        drive(0, 0, 1, P, 0, 0, 1);
        check("rst f if_ready", 32'(if_ready), 1);
        check("rst f id_valid", 32'(id_valid), 0);
        drive(0, 0, 1, P + 4, 0, 0, 1);
        check("rst g id_valid", 32'(id_valid), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check_head("rst h", P, inst_of(P), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check_head("rst i", P + 4, inst_of(P + 4), 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("rst j id_valid", 32'(id_valid), 0);

        // random handshakes against a scoreboard
        begin
            logic [31:0] pend_pc;
            logic        pend_br;
            logic [31:0] pend_ba;
            logic        v, rdy, popping;
            sb_t         e;
            pend_pc = 32'h8000_0000;
            pend_br = 1'b0;
            pend_ba = '0;
            for (int c = 0; c < 2006; c++) begin
                v   = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
                rdy = (c < 2000) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
                drive(0, 0, v, pend_pc, pend_br, pend_ba, rdy);
                popping = id_valid && id_ready;
                check("rand if_ready", 32'(if_ready),
                      32'((int'(sb.size()) - int'(popping)) < DEPTH));
                if (popping) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rand extra entry: got pc 0x%08h expected none", id_pc);
                    end else begin
                        e = sb.pop_front();
                        check("rand id_pc", id_pc, e.pc);
                        check("rand id_inst", id_inst, inst_of(e.pc));
                        check("rand id_branch", 32'(id_branch), 32'(e.br));
                        check("rand id_branch_addr", id_branch_addr, e.ba);
                    end
                end
                if (if_valid && if_ready) begin
                    sb.push_back('{pc: pend_pc, br: pend_br, ba: pend_ba});
                    pend_pc = pend_pc + 32'd4;
                    pend_br = 1'($urandom_range(0, 3) == 0);
                    pend_ba = pend_br ? $urandom : 32'd0;
                end
            end
            check("rand leftover entries", 32'(sb.size()), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
